// File: rtl/vc_flit_queue_pkg.sv
// Shared flit type and pointer helper for the multi-VC router input buffer.
package vc_flit_queue_pkg;

    localparam int unsigned PAYLOAD_W = 30;

    typedef struct packed {
        logic                 is_head;
        logic                 is_tail;
        logic [PAYLOAD_W-1:0] payload;
    } flit_t;

    // Ring-pointer advance with an explicit wrap, so any depth works.
    function automatic int unsigned ptr_inc(int unsigned ptr, int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/flit_fifo_core.sv
// Single-VC flit ring buffer: storage, wrapping head/tail pointers, occupancy count and flush.
module flit_fifo_core
    import vc_flit_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  flit_t            wr_flit,
    input  logic             rd_en,
    input  logic             flush,
    output flit_t            rd_flit,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    flit_t            mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_wr;
    logic             do_rd;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign count   = count_q;
    assign rd_flit = mem_q[tail_q];

    // Flush beats both ports; the full/empty guards keep the core safe on its own.
    assign do_wr = wr_en && !full && !flush;
    assign do_rd = rd_en && !empty && !flush;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (do_wr) begin
                head_d = PTR_W'(ptr_inc(32'(head_q), DEPTH));
            end
            if (do_rd) begin
                tail_d = PTR_W'(ptr_inc(32'(tail_q), DEPTH));
            end
            case ({do_wr, do_rd})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[head_q] <= wr_flit;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    count_in_range: assert property (@(posedge clk) disable iff (rst)
        count_q <= CNT_W'(DEPTH));

endmodule

// File: rtl/vc_flit_queue.sv
// Multi-VC router input buffer: shared push port, per-VC pop ports, credit pulses, flush and
// sticky protocol-error flags around NUM_VC flit_fifo_core instances.
module vc_flit_queue
    import vc_flit_queue_pkg::*;
#(
    parameter int unsigned NUM_VC   = 4,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned AF_LEVEL = DEPTH - 2
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  flit_t                                         push_flit,
    input  logic [(NUM_VC > 1 ? $clog2(NUM_VC) : 1)-1:0]  push_vc,
    input  logic                                          push_valid,
    output logic                                          push_ready,
    input  logic [NUM_VC-1:0]                             pop_ready,
    output logic [NUM_VC-1:0]                             pop_valid,
    output flit_t [NUM_VC-1:0]                            pop_flit,
    output logic [NUM_VC-1:0][$clog2(DEPTH + 1)-1:0]      count,
    output logic [NUM_VC-1:0]                             almost_full,
    output logic [NUM_VC-1:0]                             credit_return,
    input  logic [NUM_VC-1:0]                             flush,
    output logic                                          err_overflow,
    output logic                                          err_underflow
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [NUM_VC-1:0] vc_full;
    logic [NUM_VC-1:0] vc_empty;
    logic [NUM_VC-1:0] push_sel;
    logic [NUM_VC-1:0] wr_en;
    logic [NUM_VC-1:0] rd_en;
    logic              vc_in_range;
    logic              push_fire;
    logic [NUM_VC-1:0] credit_q;
    logic              err_overflow_q, err_overflow_d;
    logic              err_underflow_q, err_underflow_d;

    // Decode push_vc; an out-of-range VC selects nothing and is never ready.
    always_comb begin
        push_sel   = '0;
        push_ready = 1'b0;
        for (int unsigned v = 0; v < NUM_VC; v++) begin
            if (32'(push_vc) == v) begin
                push_sel[v] = 1'b1;
                push_ready  = !vc_full[v] && !flush[v];
            end
        end
        if (rst) begin
            push_ready = 1'b0;
        end
    end

    assign vc_in_range = |push_sel;
    assign push_fire   = push_valid && push_ready;
    assign wr_en       = push_fire ? push_sel : '0;
    assign rd_en       = pop_valid & pop_ready & ~flush;

    for (genvar g = 0; g < NUM_VC; g++) begin : g_vc
        flit_fifo_core #(
            .DEPTH (DEPTH),
            .CNT_W (CNT_W)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (wr_en[g]),
            .wr_flit (push_flit),
            .rd_en   (rd_en[g]),
            .flush   (flush[g]),
            .rd_flit (pop_flit[g]),
            .empty   (vc_empty[g]),
            .full    (vc_full[g]),
            .count   (count[g])
        );

        assign pop_valid[g]   = !vc_empty[g];
        assign almost_full[g] = 32'(count[g]) >= AF_LEVEL;
    end

    always_comb begin
        err_overflow_d  = err_overflow_q || (push_valid && !vc_in_range);
        err_underflow_d = err_underflow_q || (|(pop_ready & vc_empty & ~flush));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credit_q        <= '0;
            err_overflow_q  <= 1'b0;
            err_underflow_q <= 1'b0;
        end else begin
            credit_q        <= rd_en;
            err_overflow_q  <= err_overflow_d;
            err_underflow_q <= err_underflow_d;
        end
    end

    assign credit_return = credit_q;
    assign err_overflow  = err_overflow_q;
    assign err_underflow = err_underflow_q;

    credit_follows_pop: assert property (@(posedge clk) disable iff (rst)
        credit_return == $past(rd_en));

endmodule
